// File: rtl/fe_stage.sv
// fe_stage: instruction fetch stage.
//   Holds the PC, a running fetched-instruction count and the FE->DE latch.
//   The fetch is a combinational read of imem at imem_addr. The result is
//   registered into the FE latch one cycle later.
//   Redirects from AGEX insert a bubble and take priority over decode stalls.
// Optional feature macro: FE_BTB_EN
//   When defined, a 16-entry direct-mapped BTB supplies next_pc on a hit.
//   When undefined, next_pc is always PC+4 and no BTB storage exists.
module fe_stage #(
    parameter int               DBITS    = 32,
    parameter int               INSTBITS = 32,
    parameter logic [DBITS-1:0] STARTPC  = 32'h0000_0000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          from_DE_to_FE,
    input  logic [3*DBITS+1:0]            from_AGEX_to_FE,
    output logic [DBITS-3:0]              imem_addr,
    input  logic [INSTBITS-1:0]           imem_rdata,
    output logic [INSTBITS+3*DBITS:0]     FE_latch_out
);

    localparam int AGEX_W = 3*DBITS + 2;
    localparam int TAG_W  = DBITS - 6;

    // AGEX bus fields: {redirect, redirect_pc, btb_wr, btb_pc, btb_target}
    logic             redirect;
    logic [DBITS-1:0] redirect_pc;
    logic             btb_wr;
    logic [DBITS-1:0] btb_pc;
    logic [DBITS-1:0] btb_target;

    assign redirect    = from_AGEX_to_FE[AGEX_W-1];
    assign redirect_pc = from_AGEX_to_FE[AGEX_W-2 -: DBITS];
    assign btb_wr      = from_AGEX_to_FE[2*DBITS];
    assign btb_pc      = from_AGEX_to_FE[2*DBITS-1 -: DBITS];
    assign btb_target  = from_AGEX_to_FE[DBITS-1:0];

    // Fetch-side state: PC and instruction count feed the latch.
    logic [DBITS-1:0]    pc_p0;
    logic [DBITS-1:0]    cnt_p0;
    logic [DBITS-1:0]    pc_plus4_p0;
    logic [DBITS-1:0]    next_pc_p0;
    logic [DBITS-1:0]    redirect_tgt_p0;

    // FE latch fields
    logic                vld_p1;
    logic [INSTBITS-1:0] inst_p1;
    logic [DBITS-1:0]    pc_p1;
    logic [DBITS-1:0]    pcplus_p1;
    logic [DBITS-1:0]    cnt_p1;

    // Sequential PC increment; carries out of the top bit are dropped so the
    // PC wraps naturally.
    function automatic logic [DBITS-1:0] pc_inc(input logic [DBITS-1:0] pc);
        return pc + {{(DBITS-3){1'b0}}, 3'b100};
    endfunction

    // Instruction counter increment, wrapping silently.
    function automatic logic [DBITS-1:0] cnt_inc(input logic [DBITS-1:0] c);
        return c + {{(DBITS-1){1'b0}}, 1'b1};
    endfunction

    assign pc_plus4_p0     = pc_inc(pc_p0);
    assign redirect_tgt_p0 = {redirect_pc[DBITS-1:2], 2'b00};
    assign imem_addr       = pc_p0[DBITS-1:2];

`ifdef FE_BTB_EN
    // BTB storage: valid bits are control and are reset; tags and targets
    // are only meaningful behind a valid bit, so they carry no reset.
    logic [15:0]      btb_vld;
    logic [TAG_W-1:0] btb_tag [16];
    logic [DBITS-1:0] btb_tgt [16];

    logic [3:0]       lkp_idx;
    logic [3:0]       wr_idx;
    logic             btb_hit;

    assign lkp_idx = pc_p0[5:2];
    assign wr_idx  = btb_pc[5:2];

    // Lookup reads the current array contents, so a write in the same cycle
    // only becomes visible from the next cycle on.
    assign btb_hit    = btb_vld[lkp_idx] && (btb_tag[lkp_idx] == pc_p0[DBITS-1:6]);
    assign next_pc_p0 = btb_hit ? btb_tgt[lkp_idx] : pc_plus4_p0;

    // Valid bits: cleared on reset, set by any AGEX write regardless of stall
    // or redirect.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btb_vld <= '0;
        end else if (btb_wr) begin
            btb_vld[wr_idx] <= 1'b1;
        end
    end

    // Tag and target payload written alongside the valid bit.
    always_ff @(posedge clk) begin
        if (btb_wr) begin
            btb_tag[wr_idx] <= btb_pc[DBITS-1:6];
            btb_tgt[wr_idx] <= btb_target;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{redirect_pc[1:0], btb_pc[1:0]};
`else
    assign next_pc_p0 = pc_plus4_p0;

    logic unused_bits;
    assign unused_bits = ^{redirect_pc[1:0], btb_wr, btb_pc, btb_target};
`endif

    // PC / count / FE latch update: redirect beats stall, stall holds all.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_p0     <= STARTPC;
            cnt_p0    <= '0;
            vld_p1    <= 1'b0;
            inst_p1   <= '0;
            pc_p1     <= '0;
            pcplus_p1 <= '0;
            cnt_p1    <= '0;
        end else if (redirect) begin
            // Bubble into decode; the count is not charged for it.
            pc_p0     <= redirect_tgt_p0;
            vld_p1    <= 1'b0;
            inst_p1   <= '0;
            pc_p1     <= '0;
            pcplus_p1 <= '0;
            cnt_p1    <= '0;
        end else if (!from_DE_to_FE) begin
            // ---- stage boundary: imem read at pc_p0 -> FE latch ----
            pc_p0     <= next_pc_p0;
            cnt_p0    <= cnt_inc(cnt_p0);
            vld_p1    <= 1'b1;
            inst_p1   <= imem_rdata;
            pc_p1     <= pc_p0;
            pcplus_p1 <= pc_plus4_p0;
            cnt_p1    <= cnt_p0;
        end
    end

    assign FE_latch_out = {vld_p1, inst_p1, pc_p1, pcplus_p1, cnt_p1};

endmodule

// File: tb/tb_fe_stage.sv
// tb_fe_stage: directed self-checking bench for fe_stage.
// Instruction memory returns {2'b10, word_address} for every address.
module tb_fe_stage;

    localparam int DBITS    = 32;
    localparam int INSTBITS = 32;
    localparam logic [31:0] STARTPC = 32'h0000_0000;

    logic         clk = 1'b0;
    logic         reset;
    logic         stall;
    logic         redirect;
    logic [31:0]  redirect_pc;
    logic         btb_wr;
    logic [31:0]  btb_pc;
    logic [31:0]  btb_target;
    logic [97:0]  agex;
    logic [29:0]  imem_addr;
    logic [31:0]  imem_rdata;
    logic [128:0] latch;

    int checks = 0;
    int errors = 0;

    assign agex       = {redirect, redirect_pc, btb_wr, btb_pc, btb_target};
    assign imem_rdata = {2'b10, imem_addr};

    fe_stage #(
        .DBITS    (DBITS),
        .INSTBITS (INSTBITS),
        .STARTPC  (STARTPC)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .from_DE_to_FE   (stall),
        .from_AGEX_to_FE (agex),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .FE_latch_out    (latch)
    );

    always #5 clk = ~clk;

    // Expected latch contents for a valid fetch of pc with count cnt.
    function automatic logic [128:0] exp_fetch(input logic [31:0] pc, input logic [31:0] cnt);
        logic [31:0] inst;
        inst = {2'b10, pc[31:2]};
        return {1'b1, inst, pc, pc + 32'd4, cnt};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        btb_wr      = 1'b0;
        btb_pc      = '0;
        btb_target  = '0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        clear_in();
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        clear_in();
        reset = 1'b0;
        #12;
        checks++;
        if (latch !== '0) begin
            errors++;
            $display("FAIL reset_latch got %h exp 0", latch);
        end
        checks++;
        if (imem_addr !== 30'h0) begin
            errors++;
            $display("FAIL reset_addr got %h exp 0", imem_addr);
        end
        stall = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'h0000_0500;
        step();
        checks++;
        if (latch !== '0 || imem_addr !== 30'h0) begin
            errors++;
            $display("FAIL reset_hold latch %h addr %h exp 0/0", latch, imem_addr);
        end
        clear_in();
    endtask

    task automatic test_free_run();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (latch !== exp_fetch(32'(4*i), 32'(i))) begin
                errors++;
                $display("FAIL free_run_latch%0d got %h exp %h", i, latch, exp_fetch(32'(4*i), 32'(i)));
            end
            checks++;
            if (imem_addr !== 30'(i+1)) begin
                errors++;
                $display("FAIL free_run_addr%0d got %h exp %h", i, imem_addr, 30'(i+1));
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        step();
        step();
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (latch !== exp_fetch(32'h4, 32'd1)) begin
                errors++;
                $display("FAIL stall_latch%0d got %h exp %h", i, latch, exp_fetch(32'h4, 32'd1));
            end
            checks++;
            if (imem_addr !== 30'h2) begin
                errors++;
                $display("FAIL stall_addr%0d got %h exp 2", i, imem_addr);
            end
        end
        stall = 1'b0;
        step();
        checks++;
        if (latch !== exp_fetch(32'h8, 32'd2)) begin
            errors++;
            $display("FAIL stall_release got %h exp %h", latch, exp_fetch(32'h8, 32'd2));
        end
    endtask

    // Continues from test_stall: PC=0xC, count=3.
    task automatic test_redirect_stall();
        stall       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        step();
        clear_in();
        checks++;
        if (latch !== '0) begin
            errors++;
            $display("FAIL redir_bubble got %h exp 0", latch);
        end
        checks++;
        if (imem_addr !== 30'h40) begin
            errors++;
            $display("FAIL redir_addr got %h exp 40", imem_addr);
        end
        step();
        checks++;
        if (latch !== exp_fetch(32'h100, 32'd3)) begin
            errors++;
            $display("FAIL redir_fetch got %h exp %h", latch, exp_fetch(32'h100, 32'd3));
        end
    endtask

    // Continues: PC=0x104, count=4.
    task automatic test_wrap();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        clear_in();
        checks++;
        if (imem_addr !== 30'h3FFF_FFFF) begin
            errors++;
            $display("FAIL wrap_addr_top got %h exp 3fffffff", imem_addr);
        end
        step();
        checks++;
        if (latch !== exp_fetch(32'hFFFF_FFFC, 32'd4) || latch[63:32] !== 32'h0) begin
            errors++;
            $display("FAIL wrap_fetch got %h exp %h", latch, exp_fetch(32'hFFFF_FFFC, 32'd4));
        end
        checks++;
        if (imem_addr !== 30'h0) begin
            errors++;
            $display("FAIL wrap_next_pc got %h exp 0", imem_addr);
        end
        step();
        checks++;
        if (latch !== exp_fetch(32'h0, 32'd5)) begin
            errors++;
            $display("FAIL wrap_after got %h exp %h", latch, exp_fetch(32'h0, 32'd5));
        end
    endtask

    // Continues: PC=0x4, count=6.
    task automatic test_back_to_back();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0020;
        step();
        redirect_pc = 32'h0000_0030;
        step();
        clear_in();
        checks++;
        if (latch !== '0 || imem_addr !== 30'hC) begin
            errors++;
            $display("FAIL b2b_bubble latch %h addr %h exp 0/c", latch, imem_addr);
        end
        step();
        checks++;
        if (latch !== exp_fetch(32'h30, 32'd6)) begin
            errors++;
            $display("FAIL b2b_fetch got %h exp %h", latch, exp_fetch(32'h30, 32'd6));
        end
    endtask

`ifndef FE_BTB_EN
    // Continues: PC=0x34, count=7. BTB fields must have no effect.
    task automatic test_btb_ignored();
        btb_wr     = 1'b1;
        btb_pc     = 32'h0000_0038;
        btb_target = 32'h0000_0500;
        step();
        clear_in();
        step();
        checks++;
        if (latch !== exp_fetch(32'h38, 32'd8)) begin
            errors++;
            $display("FAIL nobtb_fetch got %h exp %h", latch, exp_fetch(32'h38, 32'd8));
        end
        checks++;
        if (imem_addr !== 30'hF) begin
            errors++;
            $display("FAIL nobtb_next_pc got %h exp f", imem_addr);
        end
    endtask
`else
    task automatic test_btb();
        do_reset();
        btb_wr     = 1'b1;
        btb_pc     = 32'h0000_0040;
        btb_target = 32'h0000_0200;
        step();
        clear_in();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0040;
        step();
        clear_in();
        step();
        checks++;
        if (latch !== exp_fetch(32'h40, 32'd1)) begin
            errors++;
            $display("FAIL btb_fetch40 got %h exp %h", latch, exp_fetch(32'h40, 32'd1));
        end
        checks++;
        if (imem_addr !== 30'h80) begin
            errors++;
            $display("FAIL btb_hit_next got %h exp 80", imem_addr);
        end
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0080;
        step();
        clear_in();
        step();
        checks++;
        if (imem_addr !== 30'h21) begin
            errors++;
            $display("FAIL btb_tag_miss got %h exp 21", imem_addr);
        end
        // Write at the index being looked up: lookup still sees the old entry.
        btb_wr     = 1'b1;
        btb_pc     = 32'h0000_0084;
        btb_target = 32'h0000_0300;
        step();
        clear_in();
        checks++;
        if (imem_addr !== 30'h22) begin
            errors++;
            $display("FAIL btb_same_cycle got %h exp 22", imem_addr);
        end
    endtask
`endif

    task automatic test_async_reset();
        do_reset();
        step();
        step();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0300;
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (latch !== '0) begin
            errors++;
            $display("FAIL async_latch got %h exp 0", latch);
        end
        checks++;
        if (imem_addr !== 30'h0) begin
            errors++;
            $display("FAIL async_addr got %h exp 0", imem_addr);
        end
        step();
        clear_in();
        reset = 1'b1;
        step();
        checks++;
        if (latch !== exp_fetch(STARTPC, 32'd0)) begin
            errors++;
            $display("FAIL async_restart got %h exp %h", latch, exp_fetch(STARTPC, 32'd0));
        end
        checks++;
        if (imem_addr !== 30'h1) begin
            errors++;
            $display("FAIL async_next got %h exp 1", imem_addr);
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_stall();
        test_redirect_stall();
        test_wrap();
        test_back_to_back();
`ifndef FE_BTB_EN
        test_btb_ignored();
`else
        test_btb();
`endif
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule
